// File: rtl/div_pkg.sv
// Shared widths, state encoding and cell transistor costs for the divider and its
// reconstruct/check path.
package div_pkg;
    localparam int QW    = 8;
    localparam int BW    = 5;
    localparam int AW    = QW + BW;
    localparam int NCYC  = 8;
    localparam int NUM_W = 51;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Transistor cost of the primitive cells used in this slice.
    localparam int T_AND2 = 6;   // MUXP-style operand gate
    localparam int T_FA   = 28;  // FSP ripple-chain full adder
    localparam int T_DFF  = 26;  // REGP/FD2 flop with async clear
endpackage

// File: rtl/div_check_mul_step.sv
// Combinational AW-bit conditional adder: sum = acc + (sel ? bsh : 0), built as a
// gated-operand ripple chain; reports its own transistor count.
module mul_step
    import div_pkg::*;
#(
    parameter int W = div_pkg::AW
)(
    input  logic [W-1:0]     acc,
    input  logic [W-1:0]     bsh,
    input  logic             sel,
    output logic [W-1:0]     sum,
    output logic [NUM_W-1:0] number
);
    logic [W:0]   c;
    logic [W-1:0] addend;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign addend[i] = bsh[i] & sel;
        assign sum[i]    = acc[i] ^ addend[i] ^ c[i];
        assign c[i+1]    = (acc[i] & addend[i]) | (c[i] & (acc[i] ^ addend[i]));
    end

    assign number = NUM_W'(W * (T_AND2 + T_FA));
endmodule

// File: rtl/div_check_mul.sv
// Reconstructs a = q*b + r by iterative shift-add (one quotient bit per clock) and flags
// triples no legal 8-bit division could produce. Define EARLY_TERM_EN to finish as soon
// as the remaining quotient bits are all zero.
module div_check_mul
    import div_pkg::*;
#(
    parameter int QW = div_pkg::QW,
    parameter int BW = div_pkg::BW,
    localparam int AW = QW + BW
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [QW-1:0]    i_q,
    input  logic [BW-1:0]    i_b,
    input  logic [BW-1:0]    i_r,
    output logic [AW-1:0]    o_a,
    output logic             o_err,
    output logic             o_out_valid,
    output logic [NUM_W-1:0] number
);
    localparam int CW    = $clog2(QW);
    localparam int NFLOP = 1 + AW + QW + AW + CW + 1 + AW + 1 + 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, bsh, sum;
    logic [QW-1:0]   qsh;
    logic [CW-1:0]   cnt;
    logic            err_l, accept, last;
    logic [NUM_W-1:0] step_num;

    assign accept = i_in_valid & o_in_ready;

`ifdef EARLY_TERM_EN
    assign last = (cnt == CW'(QW - 1)) | (qsh[QW-1:1] == '0);
`else
    assign last = (cnt == CW'(QW - 1));
`endif

    mul_step #(.W(AW)) u_step (
        .acc    (acc),
        .bsh    (bsh),
        .sel    (qsh[0]),
        .sum    (sum),
        .number (step_num)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_in_valid) state_nxt = RUN;
            RUN:     if (last)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            bsh   <= '0;
            qsh   <= '0;
            cnt   <= '0;
            err_l <= 1'b0;
        end else if (accept) begin
            acc   <= AW'(i_r);
            bsh   <= AW'(i_b);
            qsh   <= i_q;
            cnt   <= '0;
            err_l <= (i_b == '0) | (i_r >= i_b);
        end else if (state == RUN) begin
            acc <= sum;
            bsh <= bsh << 1;
            qsh <= qsh >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers hold until the next completion; the strobe lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_a         <= '0;
            o_err       <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            o_out_valid <= (state == RUN) & last;
            if ((state == RUN) & last) begin
                o_a   <= sum;
                o_err <= err_l | (|sum[AW-1:QW]);
            end
        end
    end

    assign number = step_num + NUM_W'(NFLOP * T_DFF);
endmodule

// File: tb/tb_div_check_mul.sv
// Scoreboard bench for div_check_mul: driver pushes reference results, monitor pops
// and compares on each o_out_valid strobe, and tracks o_in_ready against the model.
module tb_div_check_mul;
    import div_pkg::*;

    typedef struct {
        logic [12:0] a;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  i_q = '0;
    logic [4:0]  i_b = '0;
    logic [4:0]  i_r = '0;
    logic [12:0] o_a;
    logic        o_err;
    logic        o_out_valid;
    logic [50:0] number;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_end = 0;
    exp_t sb[$];

    div_check_mul dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_q         (i_q),
        .i_b         (i_b),
        .i_r         (i_r),
        .o_a         (o_a),
        .o_err       (o_err),
        .o_out_valid (o_out_valid),
        .number      (number)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int latency(input int q);
`ifdef EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < 8; i++) if (q >= (1 << i)) h = i;
        return h + 1;
`else
        return 8;
`endif
    endfunction

    task automatic send(input int q, input int b, input int r);
        exp_t e;
        int   n;
        int   want;
        n = 0;
        @(negedge clk);
        i_q = 8'(q); i_b = 5'(b); i_r = 5'(r); i_in_valid = 1'b1;
        want = (cyc + 1 > busy_end + 1) ? cyc + 1 : busy_end + 1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            i_in_valid = 1'b0;
            check("accept_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        check("accept_cycle", cyc, want);
        e.a       = 13'(q * b + r);
        e.err     = (b == 0) || (r >= b) || (q * b + r > 255);
        e.acc_cyc = cyc;
        e.lat     = latency(q);
        busy_end  = cyc + e.lat;
        sb.push_back(e);
    endtask

    // Monitor: ready tracking every cycle, scoreboard compare on each strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", o_in_ready, cyc >= busy_end);
            if (o_out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("o_a", o_a, e.a);
                    check("o_err", o_err, e.err);
                    check("latency", cyc - e.acc_cyc, e.lat);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_o_a", o_a, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_out_valid", o_out_valid, 0);
        check("rst_o_in_ready", o_in_ready, 1);
        check("number", number, 13 * (T_AND2 + T_FA) + 54 * T_DFF);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed triples
        send(25, 10, 3);
        send(255, 31, 30);
        send(3, 5, 5);
        send(7, 0, 4);
        send(1, 9, 2);
        send(128, 9, 2);
        send(0, 17, 16);

        // Handshake: second triple held valid while the first is busy
        send(1, 1, 0);
        repeat (2) @(posedge clk);
        send(2, 2, 1);

        // Reset mid-run discards the partial result
        send(100, 2, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        busy_end = 0;
        @(negedge clk);
        check("midrst_o_a", o_a, 0);
        check("midrst_o_err", o_err, 0);
        check("midrst_o_out_valid", o_out_valid, 0);
        check("midrst_o_in_ready", o_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(100, 2, 1);

        // Randomized triples with random idle gaps
        for (int k = 0; k < 40; k++) begin
            send($urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 31));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
